// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use hazard detection
module fwd_hazard_unit #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regw,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall,
  output logic [FW-1:0]    ex_fwd_a,
  output logic [FW-1:0]    ex_fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  // Slot 0 holds the instruction now in EX, higher slots are older.
  logic       slot_valid [DEPTH];
  logic [4:0] slot_rd    [DEPTH];
  logic       slot_regw  [DEPTH];
  logic       slot_load  [DEPTH];

  logic [FW-1:0] sel_a_raw, sel_b_raw;
  logic [FW-1:0] sel_a, sel_b;
  logic          ld_a, ld_b;
  logic          advance;

  // Youngest matching producer wins: scan oldest-first so lower slots overwrite.
  // The oldest slot is already retiring and is never a forwarding source.
  always_comb begin
    sel_a_raw = '0;
    sel_b_raw = '0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      if (slot_valid[i] && slot_regw[i] && (slot_rd[i] != 5'd0) && (slot_rd[i] == id_rs1)) begin
        sel_a_raw = FW'(i + 1);
        ld_a      = slot_load[i] && (i < LOAD_LAT);
      end
      if (slot_valid[i] && slot_regw[i] && (slot_rd[i] != 5'd0) && (slot_rd[i] == id_rs2)) begin
        sel_b_raw = FW'(i + 1);
        ld_b      = slot_load[i] && (i < LOAD_LAT);
      end
    end
  end

  // Unused sources never forward and never stall; reset and flush suppress the stall.
  always_comb begin
    sel_a   = id_use_rs1 ? sel_a_raw : '0;
    sel_b   = id_use_rs2 ? sel_b_raw : '0;
    stall   = !rst && id_valid && !flush && ((id_use_rs1 && ld_a) || (id_use_rs2 && ld_b));
    advance = id_valid && !stall && !flush;
  end

  // Shift the scoreboard each cycle; slot 0 takes the ID instruction or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_valid[i] <= 1'b0;
      end
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        slot_valid[i] <= slot_valid[i-1];
        slot_rd[i]    <= slot_rd[i-1];
        slot_regw[i]  <= slot_regw[i-1];
        slot_load[i]  <= slot_load[i-1];
      end
      slot_valid[0] <= advance;
      slot_rd[0]    <= id_rd;
      slot_regw[0]  <= id_regw;
      slot_load[0]  <= id_load;
    end
  end

  // Register forwarding selects for the instruction entering EX; bubbles read the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_fwd_a <= '0;
      ex_fwd_b <= '0;
    end else begin
      ex_fwd_a <= advance ? sel_a : '0;
      ex_fwd_b <= advance ? sel_b : '0;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard testbench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_use_rs1, id_use_rs2, id_regw, id_load, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic [1:0] stall_cnt;

  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regw(id_regw), .id_load(id_load),
    .flush(flush), .stall(stall),
    .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   tag;
    logic chk_regs;
    logic st;
    logic [1:0] fa, fb, cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tag_n    = 0;

  task automatic check(input string name, input int tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s step %0d: got %0d expected %0d", name, tag, act, exp);
  endtask

  // Apply one cycle of ID inputs and queue the outputs expected during that cycle.
  task automatic step(input logic r, input logic v,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic w, input logic ld, input logic fl,
                      input logic es, input logic [1:0] efa, input logic [1:0] efb,
                      input logic [1:0] ecnt, input logic chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regw = w; id_load = ld; flush = fl;
    e.tag = tag_n; e.chk_regs = chk; e.st = es; e.fa = efa; e.fb = efb; e.cnt = ecnt;
    exp_q.push_back(e);
    tag_n++;
  endtask

  task automatic nop(input logic [1:0] efa, input logic [1:0] efb, input logic [1:0] ecnt);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, efa, efb, ecnt, 1);
  endtask

  // Monitor: outputs are sampled mid-cycle and compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", e.tag, int'(stall), int'(e.st));
        if (e.chk_regs) begin
          check("ex_fwd_a", e.tag, int'(ex_fwd_a), int'(e.fa));
          check("ex_fwd_b", e.tag, int'(ex_fwd_b), int'(e.fb));
          check("stall_cnt", e.tag, int'(stall_cnt), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_regw = 0; id_load = 0; flush = 0;

    // reset with a loaded-looking ID instruction: stall must stay low
    step(1, 1, 5, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 1);
    // ALU producer x5 then consumer rs1=x5
    step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(1, 0, 0);
    nop(0, 0, 0);
    // load x5 then consumer rs2=x5: one stall cycle, then select 2
    step(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(0, 2, 1);
    nop(0, 0, 1);
    // two producers of x7: youngest wins
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(1, 0, 1);
    // x0 never forwards; unused source never stalls
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 1, 1);
    step(0, 1, 3, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(0, 0, 1);
    // flush during a load-use stall: no stall, flushed load does not enter slot 0
    step(0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1, 1);
    step(0, 1, 6, 1, 0, 0, 6, 1, 1, 1, 0, 0, 0, 1, 1);
    step(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    nop(2, 0, 1);
    // reset with load in slot 0 and dependent consumer in ID
    step(0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 1, 1);
    step(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(0, 0, 0);
    // five load-use pairs: counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      logic [1:0] c_now, c_next, fa_a;
      c_now  = (k >= 3) ? 2'd3 : 2'(k);
      c_next = (k >= 2) ? 2'd3 : 2'(k + 1);
      fa_a   = (k == 0) ? 2'd0 : 2'd2;
      step(0, 1, 0, 0, 0, 0, 10, 1, 1, 0, 0, fa_a, 0, c_now, 1);
      step(0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, c_now, 1);
      step(0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, c_next, 1);
    end
    nop(2, 0, 3);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
